// File: rtl/bsg_counter_clear_up_down_one_hot_pkg.sv
// bsg_counter_clear_up_down_one_hot_pkg: step encoding shared by the counter and its one-hot stepper
package bsg_counter_clear_up_down_one_hot_pkg;

  typedef enum logic [1:0] {STEP_NONE, STEP_UP, STEP_DOWN} step_e;

  // Both or neither request cancels out to no step
  function automatic step_e step_of(logic up, logic down);
    return (up == down) ? STEP_NONE : (up ? STEP_UP : STEP_DOWN);
  endfunction

endpackage

// File: rtl/bsg_counter_clear_up_down_one_hot_if.sv
// bsg_counter_clear_up_down_one_hot_if: control requests and count outputs of the one-hot counter
interface bsg_counter_clear_up_down_one_hot_if #(parameter int max_val_p = 32);
  localparam int bw_lp = $clog2(max_val_p + 1);
  logic                 clear_i;
  logic                 up_i;
  logic                 down_i;
  logic [max_val_p:0]   count_r_o;
  logic [bw_lp-1:0]     count_bin_r_o;
  logic                 at_zero_o;
  logic                 at_max_o;
  logic                 wrap_r_o;
  modport master (output clear_i, up_i, down_i,
                  input  count_r_o, count_bin_r_o, at_zero_o, at_max_o, wrap_r_o);
  modport slave  (input  clear_i, up_i, down_i,
                  output count_r_o, count_bin_r_o, at_zero_o, at_max_o, wrap_r_o);
endinterface

// File: rtl/bsg_counter_clear_up_down_one_hot_step.sv
// bsg_one_hot_step: combinational +1/-1 rotate or saturate of a one-hot vector with end-of-range flag
module bsg_one_hot_step
  import bsg_counter_clear_up_down_one_hot_pkg::*;
#(
  parameter int width_p    = 33,
  parameter int saturate_p = 0
) (
  input  logic [width_p-1:0] v_i,
  input  step_e              step_i,
  output logic [width_p-1:0] v_o,
  output logic               end_o
);
  localparam logic sat_lp = (saturate_p != 0);
  logic [width_p-1:0] rot_up, rot_dn;
  logic top, bot;
  always_comb begin
    rot_up = {v_i[width_p-2:0], v_i[width_p-1]};
    rot_dn = {v_i[0], v_i[width_p-1:1]};
    top    = v_i[width_p-1];
    bot    = v_i[0];
    v_o    = (step_i == STEP_UP)   ? ((sat_lp && top) ? v_i : rot_up) :
             (step_i == STEP_DOWN) ? ((sat_lp && bot) ? v_i : rot_dn) : v_i;
    end_o  = ((step_i == STEP_UP) && top) || ((step_i == STEP_DOWN) && bot);
  end
endmodule

// File: rtl/bsg_counter_clear_up_down_one_hot.sv
// bsg_counter_clear_up_down_one_hot: clearable up/down counter with one-hot state and a lockstep binary mirror
module bsg_counter_clear_up_down_one_hot
  import bsg_counter_clear_up_down_one_hot_pkg::*;
#(
  parameter int max_val_p  = 32,
  parameter int init_val_p = 0,
  parameter int saturate_p = 0
) (
  input logic clk_i,
  input logic reset_n_i,
  bsg_counter_clear_up_down_one_hot_if.slave bus
);
  localparam int w_lp  = max_val_p + 1;
  localparam int bw_lp = $clog2(w_lp);
  localparam logic sat_lp = (saturate_p != 0);
  localparam logic [w_lp-1:0]  init_oh_lp  = w_lp'(1) << init_val_p;
  localparam logic [bw_lp-1:0] init_bin_lp = bw_lp'(init_val_p);
  localparam logic [bw_lp-1:0] max_bin_lp  = bw_lp'(max_val_p);

  if (max_val_p < 1) begin : g_bad_max
    $error("max_val_p must be at least 1");
  end
  if (init_val_p < 0 || init_val_p > max_val_p) begin : g_bad_init
    $error("init_val_p must lie in 0..max_val_p");
  end

  logic [w_lp-1:0]  count_q, count_d, base_oh;
  logic [bw_lp-1:0] bin_q, bin_d, base_bin;
  logic             wrap_q, wrap_d, end_l, en;
  step_e            step;

  bsg_one_hot_step #(.width_p(w_lp), .saturate_p(saturate_p)) u_step (
    .v_i    (base_oh),
    .step_i (step),
    .v_o    (count_d),
    .end_o  (end_l)
  );

  // The binary mirror is stepped independently so it never depends on decoding the one-hot state
  always_comb begin
    step     = step_of(bus.up_i, bus.down_i);
    en       = bus.clear_i | bus.up_i | bus.down_i;
    base_oh  = bus.clear_i ? init_oh_lp : count_q;
    base_bin = bus.clear_i ? init_bin_lp : bin_q;
    bin_d    = (step == STEP_UP)   ? ((base_bin == max_bin_lp) ? (sat_lp ? max_bin_lp : '0) : base_bin + 1'b1) :
               (step == STEP_DOWN) ? ((base_bin == '0) ? (sat_lp ? '0 : max_bin_lp) : base_bin - 1'b1) : base_bin;
    wrap_d   = en & end_l;
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      count_q <= init_oh_lp;
      bin_q   <= init_bin_lp;
      wrap_q  <= 1'b0;
    end else begin
      wrap_q <= wrap_d;
      if (en) begin
        count_q <= count_d;
        bin_q   <= bin_d;
      end
    end
  end

  assign bus.count_r_o     = count_q;
  assign bus.count_bin_r_o = bin_q;
  assign bus.wrap_r_o      = wrap_q;
  assign bus.at_zero_o     = count_q[0];
  assign bus.at_max_o      = count_q[max_val_p];
endmodule

// File: tb/tb_bsg_counter_clear_up_down_one_hot.sv
// tb_bsg_counter_clear_up_down_one_hot: four counter configurations against an arithmetic reference model
module tb_bsg_counter_clear_up_down_one_hot;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic clr = 1'b0, up = 1'b0, dn = 1'b0;
  int checks = 0, errors = 0;

  // Configurations: (max, init, saturate)
  int mx_c[4] = '{4, 4, 4, 32};
  int mi_c[4] = '{0, 0, 2, 5};
  int ms_c[4] = '{0, 1, 0, 1};
  int mc[4];
  int mw[4];

  always #5 clk = ~clk;

  bsg_counter_clear_up_down_one_hot_if #(.max_val_p(4))  if0 ();
  bsg_counter_clear_up_down_one_hot_if #(.max_val_p(4))  if1 ();
  bsg_counter_clear_up_down_one_hot_if #(.max_val_p(4))  if2 ();
  bsg_counter_clear_up_down_one_hot_if #(.max_val_p(32)) if3 ();

  assign if0.clear_i = clr; assign if0.up_i = up; assign if0.down_i = dn;
  assign if1.clear_i = clr; assign if1.up_i = up; assign if1.down_i = dn;
  assign if2.clear_i = clr; assign if2.up_i = up; assign if2.down_i = dn;
  assign if3.clear_i = clr; assign if3.up_i = up; assign if3.down_i = dn;

  bsg_counter_clear_up_down_one_hot #(.max_val_p(4),  .init_val_p(0), .saturate_p(0)) d0 (.clk_i(clk), .reset_n_i(rst_n), .bus(if0));
  bsg_counter_clear_up_down_one_hot #(.max_val_p(4),  .init_val_p(0), .saturate_p(1)) d1 (.clk_i(clk), .reset_n_i(rst_n), .bus(if1));
  bsg_counter_clear_up_down_one_hot #(.max_val_p(4),  .init_val_p(2), .saturate_p(0)) d2 (.clk_i(clk), .reset_n_i(rst_n), .bus(if2));
  bsg_counter_clear_up_down_one_hot #(.max_val_p(32), .init_val_p(5), .saturate_p(1)) d3 (.clk_i(clk), .reset_n_i(rst_n), .bus(if3));

  // Returns next count in the low byte and the end-of-range flag in bit 8
  function automatic int model_next(int k, int c, logic cl, logic u, logic d);
    int b;
    b = cl ? mi_c[k] : c;
    if (u && !d) return (b == mx_c[k]) ? ((ms_c[k] != 0 ? b : 0) + 256) : b + 1;
    if (d && !u) return (b == 0) ? ((ms_c[k] != 0 ? 0 : mx_c[k]) + 256) : b - 1;
    return b;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    for (int k = 0; k < 4; k++) begin
      if (!rst_n) begin
        mc[k] <= mi_c[k];
        mw[k] <= 0;
      end else begin
        mc[k] <= model_next(k, mc[k], clr, up, dn) % 256;
        mw[k] <= model_next(k, mc[k], clr, up, dn) / 256;
      end
    end
  end

  task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic cmp(int k, logic [32:0] oh, logic [5:0] bin, logic w, logic z, logic m);
    chk($sformatf("d%0d_onehot", k), 64'(oh), 64'(33'(1) << mc[k]));
    chk($sformatf("d%0d_bin", k), 64'(bin), 64'(mc[k]));
    chk($sformatf("d%0d_wrap", k), 64'(w), 64'(mw[k]));
    chk($sformatf("d%0d_at_zero", k), 64'(z), 64'(mc[k] == 0));
    chk($sformatf("d%0d_at_max", k), 64'(m), 64'(mc[k] == mx_c[k]));
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      cmp(0, 33'(if0.count_r_o), 6'(if0.count_bin_r_o), if0.wrap_r_o, if0.at_zero_o, if0.at_max_o);
      cmp(1, 33'(if1.count_r_o), 6'(if1.count_bin_r_o), if1.wrap_r_o, if1.at_zero_o, if1.at_max_o);
      cmp(2, 33'(if2.count_r_o), 6'(if2.count_bin_r_o), if2.wrap_r_o, if2.at_zero_o, if2.at_max_o);
      cmp(3, 33'(if3.count_r_o), 6'(if3.count_bin_r_o), if3.wrap_r_o, if3.at_zero_o, if3.at_max_o);
    end
  end

  task automatic cyc(logic c, logic u, logic d);
    clr = c; up = u; dn = d;
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_reset();
    clr = 1'b0; up = 1'b0; dn = 1'b0;
    rst_n = 1'b0;
    #2;
    rst_n = 1'b1;
  endtask

  int exp_w[6]  = '{1, 2, 3, 4, 0, 1};
  int exp_s[6]  = '{1, 2, 3, 4, 4, 4};
  int exp_ww[6] = '{0, 0, 0, 0, 1, 0};
  int exp_sw[6] = '{0, 0, 0, 0, 1, 1};

  initial begin
    #12 rst_n = 1'b1;
    chk("reset_d0_oh", 64'(if0.count_r_o), 64'd1);
    chk("reset_d2_bin", 64'(if2.count_bin_r_o), 64'd2);
    chk("reset_d3_oh", 64'(if3.count_r_o), 64'(33'(1) << 5));
    // Hold up for six cycles: wrap counter rolls over, saturating one sticks at max
    for (int i = 0; i < 6; i++) begin
      cyc(1'b0, 1'b1, 1'b0);
      chk($sformatf("up_wrap_bin%0d", i), 64'(if0.count_bin_r_o), 64'(exp_w[i]));
      chk($sformatf("up_wrap_flag%0d", i), 64'(if0.wrap_r_o), 64'(exp_ww[i]));
      chk($sformatf("up_sat_bin%0d", i), 64'(if1.count_bin_r_o), 64'(exp_s[i]));
      chk($sformatf("up_sat_flag%0d", i), 64'(if1.wrap_r_o), 64'(exp_sw[i]));
    end
    chk("sat_at_max", 64'(if1.at_max_o), 64'd1);
    chk("d3_after_6up", 64'(if3.count_bin_r_o), 64'd11);
    cyc(1'b0, 1'b0, 1'b0);
    chk("idle_wrap_clears", 64'(if1.wrap_r_o), 64'd0);
    pulse_reset();
    cyc(1'b0, 1'b0, 1'b1);
    chk("down_wrap_oh", 64'(if0.count_r_o), 64'h10);
    chk("down_wrap_bin", 64'(if0.count_bin_r_o), 64'd4);
    chk("down_wrap_flag", 64'(if0.wrap_r_o), 64'd1);
    chk("down_sat_bin", 64'(if1.count_bin_r_o), 64'd0);
    chk("down_sat_flag", 64'(if1.wrap_r_o), 64'd1);
    pulse_reset();
    cyc(1'b0, 1'b1, 1'b0);
    cyc(1'b0, 1'b1, 1'b0);
    chk("init2_reach4", 64'(if2.count_bin_r_o), 64'd4);
    cyc(1'b1, 1'b1, 1'b0);
    chk("clear_up", 64'(if2.count_bin_r_o), 64'd3);
    cyc(1'b1, 1'b0, 1'b0);
    chk("clear_only", 64'(if2.count_bin_r_o), 64'd2);
    cyc(1'b0, 1'b1, 1'b1);
    chk("up_down_hold", 64'(if2.count_bin_r_o), 64'd2);
    chk("up_down_nowrap", 64'(if2.wrap_r_o), 64'd0);
    cyc(1'b0, 1'b1, 1'b0);
    chk("pre_async_bin", 64'(if2.count_bin_r_o), 64'd3);
    // Async reset lands between edges; outputs must follow without a clock
    #3 rst_n = 1'b0;
    #1;
    chk("async_rst_oh", 64'(if2.count_r_o), 64'h04);
    chk("async_rst_bin", 64'(if2.count_bin_r_o), 64'd2);
    chk("async_rst_d0", 64'(if0.count_r_o), 64'h01);
    chk("async_rst_wrap", 64'(if0.wrap_r_o), 64'd0);
    clr = 1'b0; up = 1'b0; dn = 1'b0;
    #2 rst_n = 1'b1;
    for (int i = 0; i < 10000; i++)
      cyc(1'($urandom_range(0, 15) == 0), 1'($urandom), 1'($urandom));
    cyc(1'b0, 1'b0, 1'b0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
